// File: rtl/riscv_pipeline_ctrl.sv
// riscv_pipeline_ctrl: RV32I 5-stage hazard / flow-control unit.
// Stall and clear controls for load-use, redirect flush and dmem hold.
// Ports: i_clk, i_rstn (async low); ID rs1/rs2 + enables; EX rd/load/
// valid/redirect; dmem req/ready; i_perf_clr. Outputs: PC stall/load,
// per-register stall/clr, o_state, o_stall_cnt, o_flush_cnt.
// Optional macro RISCV_PIPE_PERF_EN enables the saturating perf counters.
module riscv_pipeline_ctrl #(
   parameter int IMEM_LATENCY = 1,
   parameter int CNT_W        = 32
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [4:0]       i_id_rs1,
   input  logic             i_id_rs1_en,
   input  logic [4:0]       i_id_rs2,
   input  logic             i_id_rs2_en,
   input  logic [4:0]       i_ex_rd,
   input  logic             i_ex_load,
   input  logic             i_ex_valid,
   input  logic             i_ex_redirect,
   input  logic             i_dmem_req,
   input  logic             i_dmem_ready,
   input  logic             i_perf_clr,
   output logic             o_pc_stall,
   output logic             o_pc_load,
   output logic             o_if_id_stall,
   output logic             o_if_id_clr,
   output logic             o_id_ex_stall,
   output logic             o_id_ex_clr,
   output logic             o_ex_mem_stall,
   output logic             o_mem_wb_clr,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [2:0] LAT = 3'(IMEM_LATENCY);

   state_t     state_q, state_d;
   state_t     saved_q, saved_d;
   state_t     eff;
   logic [2:0] cnt_q, cnt_d;
   logic       pend_q, pend_d;
   logic       hold, redir, lu, rs1_hit, rs2_hit;

   always_comb begin
      hold    = i_dmem_req && !i_dmem_ready;
      rs1_hit = i_id_rs1_en && (i_id_rs1 == i_ex_rd);
      rs2_hit = i_id_rs2_en && (i_id_rs2 == i_ex_rd);
      lu      = i_ex_valid && i_ex_load && (i_ex_rd != 5'd0)
                && (rs1_hit || rs2_hit);
      // pend_q can only be set while holding, so it is a deferred redirect
      redir   = i_ex_redirect || pend_q;
      // On the release cycle behave as the state that was interrupted
      eff     = (state_q == HOLD) ? saved_q : state_q;
   end

   always_comb begin
      state_d        = state_q;
      saved_d        = saved_q;
      cnt_d          = cnt_q;
      pend_d         = pend_q;
      o_pc_stall     = 1'b0;
      o_pc_load      = 1'b0;
      o_if_id_stall  = 1'b0;
      o_if_id_clr    = 1'b0;
      o_id_ex_stall  = 1'b0;
      o_id_ex_clr    = 1'b0;
      o_ex_mem_stall = 1'b0;
      o_mem_wb_clr   = 1'b0;
      if (hold) begin
         o_pc_stall     = 1'b1;
         o_if_id_stall  = 1'b1;
         o_id_ex_stall  = 1'b1;
         o_ex_mem_stall = 1'b1;
         o_mem_wb_clr   = 1'b1;
         state_d        = HOLD;
         if (state_q != HOLD) begin
            saved_d = state_q;
         end
         if (i_ex_redirect) begin
            pend_d = 1'b1;
         end
      end else if (redir) begin
         o_pc_load   = 1'b1;
         o_if_id_clr = 1'b1;
         o_id_ex_clr = 1'b1;
         cnt_d       = LAT;
         pend_d      = 1'b0;
         state_d     = (IMEM_LATENCY > 0) ? FLUSH : RUN;
      end else if (eff == FLUSH) begin
         o_if_id_clr = 1'b1;
         cnt_d       = cnt_q - 3'd1;
         state_d     = (cnt_q <= 3'd1) ? RUN : FLUSH;
      end else begin
         state_d = RUN;
         if (lu) begin
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_clr   = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= RUN;
         saved_q <= RUN;
         cnt_q   <= 3'd0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   assign o_state = state_q;

`ifdef RISCV_PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (i_perf_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (o_pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (o_pc_load && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`else
   logic unused_perf_clr;
   assign unused_perf_clr = i_perf_clr;
   assign o_stall_cnt     = '0;
   assign o_flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_riscv_pipeline_ctrl.sv
// Testbench for riscv_pipeline_ctrl: directed steps plus random traffic
// checked against a behavioural model of the hazard rules.
module tb_riscv_pipeline_ctrl;

   localparam int LAT   = 2;
   localparam int CNT_W = 6;
   localparam longint SAT = (64'd1 << CNT_W) - 1;

   logic             clk;
   logic             rstn;
   logic [4:0]       rs1, rs2, rd;
   logic             e1, e2, ld, v, rdr, rq, rdy, pclr;
   logic             pc_stall, pc_load, if_id_stall, if_id_clr;
   logic             id_ex_stall, id_ex_clr, ex_mem_stall, mem_wb_clr;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   // model: wrong-path cycles left, hold flag, deferred redirect, counts
   int     m_left;
   bit     m_hold, m_pend;
   longint m_sc, m_fc;

   riscv_pipeline_ctrl #(
      .IMEM_LATENCY(LAT),
      .CNT_W(CNT_W)
   ) dut (
      .i_clk(clk),
      .i_rstn(rstn),
      .i_id_rs1(rs1),
      .i_id_rs1_en(e1),
      .i_id_rs2(rs2),
      .i_id_rs2_en(e2),
      .i_ex_rd(rd),
      .i_ex_load(ld),
      .i_ex_valid(v),
      .i_ex_redirect(rdr),
      .i_dmem_req(rq),
      .i_dmem_ready(rdy),
      .i_perf_clr(pclr),
      .o_pc_stall(pc_stall),
      .o_pc_load(pc_load),
      .o_if_id_stall(if_id_stall),
      .o_if_id_clr(if_id_clr),
      .o_id_ex_stall(id_ex_stall),
      .o_id_ex_clr(id_ex_clr),
      .o_ex_mem_stall(ex_mem_stall),
      .o_mem_wb_clr(mem_wb_clr),
      .o_state(state),
      .o_stall_cnt(stall_cnt),
      .o_flush_cnt(flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ctl();
      return {pc_stall, pc_load, if_id_stall, if_id_clr,
              id_ex_stall, id_ex_clr, ex_mem_stall, mem_wb_clr};
   endfunction

   function automatic longint sat_inc(input longint x);
      return (x >= SAT) ? SAT : x + 1;
   endfunction

   task automatic model_reset();
      m_left = 0;
      m_hold = 0;
      m_pend = 0;
      m_sc   = 0;
      m_fc   = 0;
   endtask

   // Compare current outputs against the model, then advance the model
   task automatic check_step(input string tag);
      logic [7:0] exp_ctl;
      logic [1:0] exp_st;
      longint     exp_sc, exp_fc;
      bit         hold, lu, did_stall, did_load;
      hold = rq && !rdy;
      lu = v && ld && (rd != 0) &&
           ((e1 && rs1 == rd) || (e2 && rs2 == rd));
      exp_st = m_hold ? 2'd2 : (m_left > 0 ? 2'd1 : 2'd0);
`ifdef RISCV_PIPE_PERF_EN
      exp_sc = m_sc;
      exp_fc = m_fc;
`else
      exp_sc = 0;
      exp_fc = 0;
`endif
      exp_ctl   = 8'h00;
      did_stall = 0;
      did_load  = 0;
      if (hold) begin
         exp_ctl   = 8'b1010_1011;
         did_stall = 1;
         m_hold    = 1;
         if (rdr) m_pend = 1;
      end else begin
         m_hold = 0;
         if (rdr || m_pend) begin
            exp_ctl  = 8'b0101_0100;
            did_load = 1;
            m_left   = LAT;
            m_pend   = 0;
         end else if (m_left > 0) begin
            exp_ctl = 8'b0001_0000;
            m_left--;
         end else if (lu) begin
            exp_ctl   = 8'b1010_0100;
            did_stall = 1;
         end
      end
      chk({tag, ".ctl"}, 32'(ctl()), 32'(exp_ctl));
      chk({tag, ".state"}, 32'(state), 32'(exp_st));
      chk({tag, ".scnt"}, 32'(stall_cnt), 32'(exp_sc));
      chk({tag, ".fcnt"}, 32'(flush_cnt), 32'(exp_fc));
      if (pclr) begin
         m_sc = 0;
         m_fc = 0;
      end else begin
         if (did_stall) m_sc = sat_inc(m_sc);
         if (did_load) m_fc = sat_inc(m_fc);
      end
   endtask

   task automatic cyc(input string tag,
                      input logic [4:0] a_rs1, input logic a_e1,
                      input logic [4:0] a_rs2, input logic a_e2,
                      input logic [4:0] a_rd, input logic a_ld,
                      input logic a_v, input logic a_rdr,
                      input logic a_rq, input logic a_rdy,
                      input logic a_pclr);
      @(posedge clk);
      #1;
      rs1 = a_rs1; e1 = a_e1; rs2 = a_rs2; e2 = a_e2;
      rd = a_rd; ld = a_ld; v = a_v; rdr = a_rdr;
      rq = a_rq; rdy = a_rdy; pclr = a_pclr;
      @(negedge clk);
      check_step(tag);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
          1'b0, 1'b1, 1'b0);
   endtask

   task automatic redir(input string tag);
      cyc(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
          1'b0, 1'b1, 1'b0);
   endtask

   task automatic hold(input string tag, input logic r);
      cyc(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, r,
          1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rstn = 1'b0;
      rs1 = 0; rs2 = 0; rd = 0;
      e1 = 0; e2 = 0; ld = 0; v = 0; rdr = 0;
      rq = 0; rdy = 1; pclr = 0;
      model_reset();
      #2;
      chk("rst.ctl", 32'(ctl()), 32'h0);
      chk("rst.state", 32'(state), 32'h0);
      chk("rst.scnt", 32'(stall_cnt), 32'h0);
      chk("rst.fcnt", 32'(flush_cnt), 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      // load-use on rs1, then rd=x0, then rs2 match
      cyc("lu1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0,
          1'b0, 1'b1, 1'b0);
      idle("lu1_after");
      cyc("lu_x0", 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0,
          1'b0, 1'b1, 1'b0);
      cyc("lu_rs2", 5'd1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0,
          1'b0, 1'b1, 1'b0);
      cyc("lu_noen", 5'd7, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0,
          1'b0, 1'b1, 1'b0);

      // redirect with fetch latency 2
      redir("rd0");
      idle("rd1");
      idle("rd2");
      idle("rd3");

      // data memory wait, 3 cycles
      hold("h1", 1'b0);
      hold("h2", 1'b0);
      hold("h3", 1'b0);
      idle("h_rel");

      // redirect on hold cycle 2 of 4
      hold("hr1", 1'b0);
      hold("hr2", 1'b1);
      hold("hr3", 1'b0);
      hold("hr4", 1'b0);
      idle("hr_rel");
      idle("hr_f1");
      idle("hr_f2");
      idle("hr_run");

      // load-use with redirect: redirect wins; load-use in FLUSH ignored
      cyc("lu_rdr", 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1,
          1'b0, 1'b1, 1'b0);
      cyc("lu_fl", 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0,
          1'b0, 1'b1, 1'b0);
      idle("fl_end");

      // hold in the middle of FLUSH freezes the counter
      redir("fh0");
      idle("fh1");
      hold("fh_h1", 1'b0);
      hold("fh_h2", 1'b0);
      idle("fh2");
      idle("fh_run");

      cyc("pclr", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
          1'b1, 1'b0, 1'b1);
      idle("pclr_after");

      // asynchronous reset mid-FLUSH with counter at 1
      redir("rf0");
      idle("rf1");
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      chk("arst.ctl", 32'(ctl()), 32'h0);
      chk("arst.state", 32'(state), 32'h0);
      chk("arst.scnt", 32'(stall_cnt), 32'h0);
      chk("arst.fcnt", 32'(flush_cnt), 32'h0);
      @(posedge clk);
      #2;
      rstn = 1'b1;
      idle("arst_rel");

      // random traffic
      for (int i = 0; i < 600; i++) begin
         cyc("rnd",
             5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom),
             1'($urandom_range(0, 63) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_pipeline_ctrl.md
Name: riscv_pipeline_ctrl

Overview:
- Hazard and flow-control unit for the RV32I 5-stage pipeline.
- Generates the stall and clear controls for the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB); each register's i_clr input is driven from here.
- Handles three cases: load-use bubbles, branch/jump redirect flushes stretched over the fetch latency, and a full-pipeline freeze while data memory is not ready.

Parameters:
- IMEM_LATENCY, 1: extra cycles after a redirect during which IF/ID is cleared (wrong-path fetches still in flight); 0..7.
- CNT_W, 32: width of the performance counters.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  asynchronous active-low reset
- i_id_rs1  input  5  ID-stage rs1 index
- i_id_rs1_en  input  1  ID instruction reads rs1
- i_id_rs2  input  5  ID-stage rs2 index
- i_id_rs2_en  input  1  ID instruction reads rs2
- i_ex_rd  input  5  EX-stage rd index
- i_ex_load  input  1  EX instruction is a load
- i_ex_valid  input  1  EX holds a real (non-bubble) instruction
- i_ex_redirect  input  1  EX resolved a taken branch or jump
- i_dmem_req  input  1  MEM stage issuing a data access
- i_dmem_ready  input  1  data memory accepts/completes the access
- i_perf_clr  input  1  synchronous clear of the perf counters
- o_pc_stall  output  1  hold PC
- o_pc_load  output  1  load PC with the redirect target
- o_if_id_stall  output  1  hold IF/ID
- o_if_id_clr  output  1  clear IF/ID
- o_id_ex_stall  output  1  hold ID/EX
- o_id_ex_clr  output  1  clear ID/EX (insert bubble)
- o_ex_mem_stall  output  1  hold EX/MEM
- o_mem_wb_clr  output  1  clear MEM/WB
- o_state  output  2  current FSM state
- o_stall_cnt  output  CNT_W  stall-cycle counter
- o_flush_cnt  output  CNT_W  redirect counter

Behaviour:
- All control outputs are combinational (Mealy) from the registered state and the current inputs. Decisions take effect in the same cycle; added latency is 0.

FSM states: RUN=0, FLUSH=1, HOLD=2.
- Reset: state RUN, flush counter 0, pending-redirect flag 0, perf counters 0, all control outputs 0.
- Reset is asynchronous. Asserting it mid-FLUSH or mid-HOLD returns the FSM to RUN immediately.

hold = i_dmem_req && !i_dmem_ready. Priority: hold > redirect > load-use.

Hold (any state):
- Drive o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall = 1 and o_mem_wb_clr = 1. All other outputs 0.
- Next state HOLD.
- Any i_ex_redirect seen while holding sets the pending flag.

Leaving HOLD (first cycle with !hold):
- If pending or i_ex_redirect is set, perform the redirect action (below) exactly once and clear pending.
- Otherwise return to the state saved on hold entry. A FLUSH counter is frozen during HOLD and resumes afterwards.

Redirect action:
- Drive o_pc_load = 1, o_if_id_clr = 1, o_id_ex_clr = 1.
- Load the counter with IMEM_LATENCY. Next state is FLUSH if IMEM_LATENCY > 0, else RUN.

FLUSH:
- Each cycle drive o_if_id_clr = 1 and decrement the counter. Move to RUN when it reaches 0.
- Load-use detection is suppressed in this state.
- A new redirect restarts the redirect action with the counter reloaded.

Load-use (RUN only):
- Condition: i_ex_valid && i_ex_load && i_ex_rd != 0 && ((i_id_rs1_en && i_id_rs1 == i_ex_rd) || (i_id_rs2_en && i_id_rs2 == i_ex_rd)).
- Drive o_pc_stall = 1, o_if_id_stall = 1, o_id_ex_clr = 1 for exactly one cycle. State stays RUN.

General rules:
- Stall and clear of the same register are never asserted together.
- Reads of x0 never stall.

Optional Feature:
Macro RISCV_PIPE_PERF_EN.
- Defined:
  - o_stall_cnt increments on every cycle in which o_pc_stall = 1.
  - o_flush_cnt increments once per redirect action.
  - Both counters saturate at all-ones.
  - i_perf_clr zeroes both and takes priority over an increment in the same cycle.
- Undefined: both counter outputs are tied to 0, no counter flops exist, and i_perf_clr is ignored.

Test Plan:
- Load-use: EX lw with rd=5, ID add reading rs1=5 -> exactly 1 cycle of o_pc_stall=o_if_id_stall=o_id_ex_clr=1, then 0. Repeat with rd=0 -> no stall.
- Redirect, IMEM_LATENCY=2: i_ex_redirect pulse -> cycle 0: o_pc_load=o_if_id_clr=o_id_ex_clr=1; cycles 1–2: o_if_id_clr only; cycle 3: RUN, all 0. o_flush_cnt=1 (perf build).
- Data-memory wait: i_dmem_req=1, i_dmem_ready=0 for 3 cycles -> 3 cycles of all stalls plus o_mem_wb_clr, o_state=2; released on the cycle ready=1. o_stall_cnt=3.
- Redirect during hold: redirect pulse on hold cycle 2 of 4 -> no o_pc_load while holding; o_pc_load=1 exactly once on the release cycle.
- Simultaneous load-use and redirect in RUN -> redirect action only (o_pc_stall=0). Load-use during FLUSH -> no stall.
- Reset mid-FLUSH (counter=1): i_rstn low for 1 cycle -> o_state=0 and all outputs 0 immediately; after release, no residual o_if_id_clr.
